booth_pp_accumulator: RTL

- Sequential reduction stage directly downstream of booth_encoder.
- Accepts the flat bus of Booth partial products, already encoder-positioned, through a valid/ready handshake.
- Sums TERMS_PER_CYCLE terms per clock into a 2*DATA_WIDTH accumulator and presents the final product through a valid/ready output handshake.
- Trades latency for adder area in the multiplier datapath.

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_group_adder.sv | 38 +++
 rtl/booth_pp_accumulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath: width helpers,
// pass-count helper and the accumulator FSM state encoding.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of one Booth partial product for a given operand width.
    function automatic int term_width(input int data_width);
        return 2 * data_width - 1;
    endfunction

    // Width of the full product for a given operand width.
    function automatic int result_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Number of accumulate cycles: ceil(num_terms / terms_per_cycle).
    function automatic int n_passes(input int num_terms, input int terms_per_cycle);
        return (num_terms + terms_per_cycle - 1) / terms_per_cycle;
    endfunction

endpackage

// File: rtl/booth_group_adder.sv
// Combinational adder: sign-extends one group of partial products and adds
// them to the running accumulator. Terms past the end of the bus (only
// possible in the last, partial group) contribute nothing.
module booth_group_adder #(
    parameter int NUM_TERMS       = 17,
    parameter int TERM_WIDTH      = 63,
    parameter int TERMS_PER_CYCLE = 1,
    parameter int RESULT_WIDTH    = 64,
    parameter int IDX_W           = 5
) (
    input  logic [NUM_TERMS*TERM_WIDTH-1:0] terms_i,
    input  logic [IDX_W-1:0]                group_idx,
    input  logic [RESULT_WIDTH-1:0]         acc_in,
    output logic [RESULT_WIDTH-1:0]         sum_out
);

    logic [TERM_WIDTH-1:0]   term_s;
    logic [RESULT_WIDTH-1:0] sum_s;
    int                      term_idx_s;

    // Walk the selected group, adding each in-range term sign-extended to the result width.
    always_comb begin
        sum_s      = acc_in;
        term_s     = {TERM_WIDTH{1'b0}};
        term_idx_s = 0;
        for (int k = 0; k < TERMS_PER_CYCLE; k++) begin
            term_idx_s = int'(group_idx) * TERMS_PER_CYCLE + k;
            if (term_idx_s < NUM_TERMS) begin
                term_s = terms_i[term_idx_s*TERM_WIDTH +: TERM_WIDTH];
                sum_s  = sum_s + {{(RESULT_WIDTH-TERM_WIDTH){term_s[TERM_WIDTH-1]}}, term_s};
            end else begin
                sum_s = sum_s;
            end
        end
        sum_out = sum_s;
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential reduction of Booth partial products: latches the term bus on a
// valid/ready handshake, adds TERMS_PER_CYCLE terms per cycle into a
// double-width accumulator, then offers the product on a valid/ready output.
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_TERMS       = DATA_WIDTH / 2 + 1,
    parameter int TERM_WIDTH      = term_width(DATA_WIDTH),
    parameter int TERMS_PER_CYCLE = 1,
    parameter int RESULT_WIDTH    = result_width(DATA_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_TERMS*TERM_WIDTH-1:0] pp_bus,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RESULT_WIDTH-1:0]        product,
    output logic                           busy
);

    localparam int N_PASSES = n_passes(NUM_TERMS, TERMS_PER_CYCLE);
    localparam int IDX_W    = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam int BUS_W    = NUM_TERMS * TERM_WIDTH;

    state_e                  state_q, state_d;
    logic [BUS_W-1:0]        terms_q, terms_d;
    logic [RESULT_WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    in_ready_s;
    logic [RESULT_WIDTH-1:0] group_sum_s;

    booth_group_adder #(
        .NUM_TERMS       (NUM_TERMS),
        .TERM_WIDTH      (TERM_WIDTH),
        .TERMS_PER_CYCLE (TERMS_PER_CYCLE),
        .RESULT_WIDTH    (RESULT_WIDTH),
        .IDX_W           (IDX_W)
    ) u_group_adder (
        .terms_i   (terms_q),
        .group_idx (idx_q),
        .acc_in    (acc_q),
        .sum_out   (group_sum_s)
    );

    // Next-state logic: handshakes, term capture, group stepping and the
    // DONE->ACCUM shortcut when a new set arrives as the product leaves.
    always_comb begin
        state_d    = state_q;
        terms_d    = terms_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        in_ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    terms_d = pp_bus;
                    acc_d   = {RESULT_WIDTH{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                acc_d = group_sum_s;
                if (idx_q == IDX_W'(N_PASSES - 1)) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ACCUM;
                end
            end
            DONE: begin
                in_ready_s = out_ready;
                if (out_ready && in_valid) begin
                    terms_d = pp_bus;
                    acc_d   = {RESULT_WIDTH{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ACCUM;
                end else if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == ACCUM);
    end

    // State, datapath and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            terms_q     <= {BUS_W{1'b0}};
            acc_q       <= {RESULT_WIDTH{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            terms_q     <= terms_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = acc_q;

endmodule
